// File: rtl/reg_bank_read.sv
// reg_bank_read: 32-entry register bank with write bypass and registered A/B operand latches
module reg_bank_read #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = 227
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_reg1,
    input  logic [4:0]        read_reg2,
    input  logic              a_load,
    input  logic              b_load,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              wr_ack
);
    logic [DATA_W-1:0] regs [32];
    logic [DATA_W-1:0] rd1, rd2;
    logic              wr_en;

    assign wr_en = reg_write && (write_reg != 5'd0);

    // read ports: $0 is hardwired zero, a same-cycle write to the index is forwarded
    always_comb begin
        rd1 = (read_reg1 == 5'd0) ? '0 : (wr_en && write_reg == read_reg1) ? write_data : regs[read_reg1];
        rd2 = (read_reg2 == 5'd0) ? '0 : (wr_en && write_reg == read_reg2) ? write_data : regs[read_reg2];
    end

    // bank update, operand capture and write acknowledge; reset wins over everything
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= (i == 29) ? SP_RESET : '0;
            a_out  <= '0;
            b_out  <= '0;
            wr_ack <= 1'b0;
        end else begin
            if (wr_en) regs[write_reg] <= write_data;
            if (a_load) a_out <= rd1;
            if (b_load) b_out <= rd2;
            wr_ack <= wr_en;
        end
    end
endmodule

// File: tb/tb_reg_bank_read.sv
// tb_reg_bank_read: directed vectors with a queue-based scoreboard for reg_bank_read
module tb_reg_bank_read;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  read_reg1 = '0;
    logic [4:0]  read_reg2 = '0;
    logic        a_load = 1'b0;
    logic        b_load = 1'b0;
    logic [31:0] a_out, b_out;
    logic        wr_ack;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ack;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    reg_bank_read dut (
        .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .a_load(a_load), .b_load(b_load), .a_out(a_out), .b_out(b_out), .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    // one cycle: drive inputs, let the edge happen, then queue the expected outputs
    task automatic step(input logic rn, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic al, input logic bl,
                        input logic [31:0] ea, input logic [31:0] eb, input logic eack, input string nm);
        reset_n = rn; reg_write = we; write_reg = wr; write_data = wd;
        read_reg1 = r1; read_reg2 = r2; a_load = al; b_load = bl;
        @(posedge clk);
        q.push_back('{ea, eb, eack, nm});
        #1;
    endtask

    // monitor: outputs are stable at the falling edge; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (a_out !== e.a || b_out !== e.b || wr_ack !== e.ack) begin
                    errors++;
                    $display("FAIL %s: got a=%h b=%h ack=%b expected a=%h b=%h ack=%b",
                             e.name, a_out, b_out, wr_ack, e.a, e.b, e.ack);
                end
            end
        end
    end

    initial begin
        step(0, 0, 0, 0,            0,  0,  0, 0, 32'h0,        32'h0,        0, "reset0");
        step(0, 0, 0, 0,            0,  0,  1, 1, 32'h0,        32'h0,        0, "reset1");
        step(1, 0, 0, 0,            29, 5,  1, 1, 32'd227,      32'h0,        0, "sp_reset");
        step(1, 1, 8, 32'hDEADBEEF, 0,  0,  0, 0, 32'd227,      32'h0,        1, "write8_ack");
        step(1, 0, 0, 0,            8,  0,  1, 0, 32'hDEADBEEF, 32'h0,        0, "read8");
        step(1, 1, 0, 32'hFFFFFFFF, 0,  0,  1, 1, 32'h0,        32'h0,        0, "zero_write");
        step(1, 0, 0, 0,            0,  0,  1, 1, 32'h0,        32'h0,        0, "zero_read");
        step(1, 1, 31, 32'h00400010, 31, 31, 1, 1, 32'h00400010, 32'h00400010, 1, "bypass31");
        step(1, 0, 0, 0,            31, 8,  1, 1, 32'h00400010, 32'hDEADBEEF, 0, "retain31");
        step(1, 1, 3, 32'h12345678, 0,  0,  0, 0, 32'h00400010, 32'hDEADBEEF, 1, "write3");
        step(1, 0, 0, 0,            3,  0,  1, 0, 32'h12345678, 32'hDEADBEEF, 0, "load3");
        for (int i = 0; i < 5; i++)
            step(1, 1, 3, 32'hA0 + i, 5'(i + 1), 3, 0, 0, 32'h12345678, 32'hDEADBEEF, 1, "hold");
        step(1, 0, 0, 0,            3,  0,  1, 0, 32'h000000A4, 32'hDEADBEEF, 0, "reload3");
        step(0, 1, 29, 32'h1000,    29, 29, 1, 1, 32'h0,        32'h0,        0, "reset_midwrite");
        step(1, 0, 0, 0,            29, 29, 1, 1, 32'd227,      32'd227,      0, "sp_after_reset");
        step(1, 0, 0, 0,            8,  0,  1, 0, 32'h0,        32'd227,      0, "reg8_cleared");
        step(1, 1, 29, 32'h2000,    29, 31, 1, 1, 32'h2000,     32'h0,        1, "write29_bypass");
        step(1, 0, 0, 0,            0,  29, 0, 1, 32'h2000,     32'h2000,     0, "read29");
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
